// File: rtl/pad_scan_pkg.sv
// Shared constants and helpers for the pad scan front end.
package pad_scan_pkg;

   // Default number of pads and debounce depth.
   localparam int unsigned N_PADS_DEF    = 8;
   localparam int unsigned DB_CYCLES_DEF = 4;

   // Width of the running press counter (wraps at 256).
   localparam int unsigned PRESS_CNT_W = 8;

   // Debounce counter width; never narrower than one bit.
   function automatic int unsigned db_cnt_width(input int unsigned db_cycles);
      int unsigned w;
      w = $clog2(db_cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/pad_debounce.sv
// One pad: two-flop synchroniser, debounce counter, held level and edge strobes.
module pad_debounce
   import pad_scan_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic lvl,
   output logic press,
   output logic rel
);

   localparam int unsigned      CNT_W    = db_cnt_width(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync_q;
   logic             s_q;
   logic             lvl_q;
   logic             lvl_d;
   logic             press_q;
   logic             rel_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             accept;

   // Next-state debounce: any agreeing sample restarts the count.
   always_comb begin
      accept = 1'b0;
      lvl_d  = lvl_q;
      cnt_d  = cnt_q;
      if (s_q == lvl_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         accept = 1'b1;
         lvl_d  = s_q;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers; strobes land in the same cycle as the new level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= 1'b0;
         s_q     <= 1'b0;
         lvl_q   <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         sync_q  <= raw;
         s_q     <= sync_q;
         lvl_q   <= lvl_d;
         cnt_q   <= cnt_d;
         press_q <= accept & s_q;
         rel_q   <= accept & ~s_q;
      end
   end

   assign lvl   = lvl_q;
   assign press = press_q;
   assign rel   = rel_q;

endmodule

// File: rtl/pad_scan.sv
// Pad scan top: per-pad debounce, lowest-pad encoder, any-pad flag, press counter.
module pad_scan
   import pad_scan_pkg::*;
#(
   parameter int unsigned  N_PADS    = N_PADS_DEF,
   parameter int unsigned  DB_CYCLES = DB_CYCLES_DEF,
   localparam int unsigned IDX_W     = (N_PADS > 1) ? $clog2(N_PADS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_PADS-1:0]      btn_raw,
   output logic [N_PADS-1:0]      btn_lvl,
   output logic [N_PADS-1:0]      press_pulse,
   output logic [N_PADS-1:0]      release_pulse,
   output logic [IDX_W-1:0]       pad_idx,
   output logic                   pad_valid,
   output logic [PRESS_CNT_W-1:0] press_cnt
);

   logic [PRESS_CNT_W-1:0] press_cnt_q;
   logic [PRESS_CNT_W-1:0] press_pop;

   for (genvar g = 0; g < N_PADS; g++) begin : g_pad
      pad_debounce #(
         .DB_CYCLES(DB_CYCLES)
      ) u_pad_debounce (
         .clk  (clk),
         .rst  (rst),
         .raw  (btn_raw[g]),
         .lvl  (btn_lvl[g]),
         .press(press_pulse[g]),
         .rel  (release_pulse[g])
      );
   end

   // Lowest-indexed held pad wins; scan high to low so the last hit sticks.
   always_comb begin
      pad_idx = '0;
      for (int i = int'(N_PADS) - 1; i >= 0; i--) begin
         if (btn_lvl[i]) begin
            pad_idx = IDX_W'(i);
         end
      end
   end

   assign pad_valid = |btn_lvl;

   // Population count of this cycle's press strobes.
   always_comb begin
      press_pop = '0;
      for (int i = 0; i < int'(N_PADS); i++) begin
         press_pop = press_pop + PRESS_CNT_W'(press_pulse[i]);
      end
   end

   // Running press total, wrapping naturally at the counter width.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         press_cnt_q <= '0;
      end else begin
         press_cnt_q <= press_cnt_q + press_pop;
      end
   end

   assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_pad_scan.sv
// Scoreboard bench for pad_scan: stimulus queues expected strobe events, monitor checks them.
module tb_pad_scan;

   logic       clk;
   logic       rst;
   logic [7:0] btn_raw;
   logic [7:0] btn_lvl;
   logic [7:0] press_pulse;
   logic [7:0] release_pulse;
   logic [2:0] pad_idx;
   logic       pad_valid;
   logic [7:0] press_cnt;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int         cyc;
      logic [7:0] press;
      logic [7:0] rel;
      logic [7:0] lvl;
      logic [2:0] idx;
      logic       valid;
   } ev_t;

   ev_t exp_q[$];

   pad_scan #(
      .N_PADS   (8),
      .DB_CYCLES(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_raw      (btn_raw),
      .btn_lvl      (btn_lvl),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .pad_idx      (pad_idx),
      .pad_valid    (pad_valid),
      .press_cnt    (press_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Queue the strobe event caused by a raw change (or reset release) driven now.
   task automatic expect_ev(input logic [7:0] p, input logic [7:0] r, input logic [7:0] l,
                            input logic [2:0] idx);
      ev_t e;
      e.cyc   = cyc + 6;
      e.press = p;
      e.rel   = r;
      e.lvl   = l;
      e.idx   = idx;
      e.valid = |l;
      exp_q.push_back(e);
   endtask

   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: each strobe the DUT presents must match the head of the queue.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_event: got none expected press=%0h rel=%0h at cycle %0d",
                     e.press, e.rel, e.cyc);
         end
         if ((press_pulse | release_pulse) != 8'h00) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_event: got press=%0h rel=%0h expected none (cycle %0d)",
                        press_pulse, release_pulse, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("ev_cycle", cyc, e.cyc);
               chk("ev_press", {24'b0, press_pulse}, {24'b0, e.press});
               chk("ev_release", {24'b0, release_pulse}, {24'b0, e.rel});
               chk("ev_lvl", {24'b0, btn_lvl}, {24'b0, e.lvl});
               chk("ev_idx", {29'b0, pad_idx}, {29'b0, e.idx});
               chk("ev_valid", {31'b0, pad_valid}, {31'b0, e.valid});
            end
         end
      end
   end

   initial begin
      rst     = 1'b0;
      btn_raw = 8'hFF;
      ticks(3);

      // Reset hold with every pad pressed.
      chk("rst_lvl", {24'b0, btn_lvl}, 32'h0);
      chk("rst_press", {24'b0, press_pulse}, 32'h0);
      chk("rst_release", {24'b0, release_pulse}, 32'h0);
      chk("rst_idx", {29'b0, pad_idx}, 32'h0);
      chk("rst_valid", {31'b0, pad_valid}, 32'h0);
      chk("rst_cnt", {24'b0, press_cnt}, 32'h0);

      rst = 1'b1;
      expect_ev(8'hFF, 8'h00, 8'hFF, 3'd0);
      ticks(7);
      chk("all_press_cnt", {24'b0, press_cnt}, 32'd8);
      btn_raw = 8'h00;
      expect_ev(8'h00, 8'hFF, 8'h00, 3'd0);
      ticks(8);

      // Clean press and release on pad 3.
      btn_raw = 8'h08;
      expect_ev(8'h08, 8'h00, 8'h08, 3'd3);
      ticks(8);
      chk("pad3_lvl", {24'b0, btn_lvl}, 32'h08);
      chk("pad3_idx", {29'b0, pad_idx}, 32'd3);
      chk("pad3_valid", {31'b0, pad_valid}, 32'd1);
      btn_raw = 8'h00;
      expect_ev(8'h00, 8'h08, 8'h00, 3'd0);
      ticks(8);
      chk("pad3_cnt", {24'b0, press_cnt}, 32'd9);

      // Short bounce on pad 0 must be rejected.
      btn_raw = 8'h01;
      ticks(3);
      btn_raw = 8'h00;
      ticks(10);
      chk("bounce_lvl", {24'b0, btn_lvl}, 32'h0);
      chk("bounce_cnt", {24'b0, press_cnt}, 32'd9);

      // One-cycle low glitch while pad 0 is held.
      btn_raw = 8'h01;
      expect_ev(8'h01, 8'h00, 8'h01, 3'd0);
      ticks(8);
      btn_raw = 8'h00;
      ticks(1);
      btn_raw = 8'h01;
      ticks(10);
      chk("glitch_lvl", {24'b0, btn_lvl}, 32'h01);
      chk("glitch_valid", {31'b0, pad_valid}, 32'd1);
      btn_raw = 8'h00;
      expect_ev(8'h00, 8'h01, 8'h00, 3'd0);
      ticks(8);
      chk("glitch_cnt", {24'b0, press_cnt}, 32'd10);

      // Simultaneous press of pads 2 and 5, then staggered release.
      btn_raw = 8'h24;
      expect_ev(8'h24, 8'h00, 8'h24, 3'd2);
      ticks(8);
      chk("simul_cnt", {24'b0, press_cnt}, 32'd12);
      btn_raw = 8'h20;
      expect_ev(8'h00, 8'h04, 8'h20, 3'd5);
      ticks(8);
      chk("simul_idx", {29'b0, pad_idx}, 32'd5);
      btn_raw = 8'h00;
      expect_ev(8'h00, 8'h20, 8'h00, 3'd0);
      ticks(8);

      // Clear the counter, then 257 presses on pad 7 must wrap to 1.
      rst = 1'b0;
      ticks(2);
      chk("wrap_rst_cnt", {24'b0, press_cnt}, 32'd0);
      rst = 1'b1;
      ticks(2);
      for (int n = 0; n < 257; n++) begin
         btn_raw = 8'h80;
         expect_ev(8'h80, 8'h00, 8'h80, 3'd7);
         ticks(7);
         btn_raw = 8'h00;
         expect_ev(8'h00, 8'h80, 8'h00, 3'd0);
         ticks(7);
      end
      ticks(2);
      chk("wrap_cnt", {24'b0, press_cnt}, 32'd1);

      // Asynchronous reset four cycles into a pad 1 press.
      btn_raw = 8'h02;
      ticks(4);
      #2;
      rst = 1'b0;
      #1;
      chk("async_cnt", {24'b0, press_cnt}, 32'd0);
      chk("async_lvl", {24'b0, btn_lvl}, 32'h0);
      chk("async_press", {24'b0, press_pulse}, 32'h0);
      ticks(3);
      rst = 1'b1;
      expect_ev(8'h02, 8'h00, 8'h02, 3'd1);
      ticks(8);
      chk("async_after_cnt", {24'b0, press_cnt}, 32'd1);
      chk("async_after_lvl", {24'b0, btn_lvl}, 32'h02);
      btn_raw = 8'h00;
      expect_ev(8'h00, 8'h02, 8'h00, 3'd0);
      ticks(10);

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
